// File: rtl/conv_sequencer_if.sv
// Memory bus and converter handshake seen by conv_sequencer.
// master = sequencer side, slave = memory/converter side.
interface conv_sequencer_if;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        conv_start;
    logic [15:0] conv_operand;
    logic        conv_done;
    logic [15:0] conv_result;

    modport master (
        output mem_addr, mem_rd, mem_we, mem_wdata, conv_start, conv_operand,
        input  mem_rdata, conv_done, conv_result
    );

    modport slave (
        input  mem_addr, mem_rd, mem_we, mem_wdata, conv_start, conv_operand,
        output mem_rdata, conv_done, conv_result
    );
endinterface

// File: rtl/conv_sequencer.sv
// Streams 16-bit operands from memory through an external converter and writes results back.
// Optional CONV_TIMEOUT_EN: 255-cycle WAIT timeout sets sticky err and substitutes 16'h7E00.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RD_LO  | read strobe for operand low byte
// RD_HI  | capture low byte, read strobe for high byte
// LAUNCH | capture high byte, one-cycle conv_start
// WAIT   | waiting for conv_done (or timeout)
// WR_LO  | write result low byte
// WR_HI  | write result high byte, next op or finish
// DONE   | batch complete, waiting for start
module conv_sequencer #(
    parameter int         NUM_OPS  = 1,
    parameter logic [7:0] SRC_BASE = 8'd0,
    parameter logic [7:0] DST_BASE = 8'd2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done,
    output logic busy,
    output logic err,
    conv_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, LAUNCH, WAIT, WR_LO, WR_HI, DONE
    } state_t;

    localparam logic [6:0] LAST_K = 7'(NUM_OPS - 1);

    state_t      state;
    logic [6:0]  k;
    logic [7:0]  k_off, k_nxt_off;
    logic [7:0]  addr_q, wdata_q, res_hi;
    logic        rd_q, we_q, cstart_q, done_q, busy_q;
    logic [15:0] op_q;
    logic        wait_exit;
    logic [15:0] wait_res;

    assign k_off     = {k, 1'b0};
    assign k_nxt_off = {k + 7'd1, 1'b0};

`ifdef CONV_TIMEOUT_EN
    logic [7:0] tmr;
    logic       err_q;
    assign wait_exit = bus.conv_done || (tmr == 8'd0);
    assign wait_res  = bus.conv_done ? bus.conv_result : 16'h7E00;
    assign err       = err_q;
`else
    assign wait_exit = bus.conv_done;
    assign wait_res  = bus.conv_result;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            k        <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            res_hi   <= '0;
            op_q     <= '0;
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            cstart_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CONV_TIMEOUT_EN
            tmr      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RD_LO;
                        k      <= '0;
                        addr_q <= SRC_BASE;
                        rd_q   <= 1'b1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
`ifdef CONV_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                RD_LO: begin
                    state  <= RD_HI;
                    addr_q <= SRC_BASE + k_off + 8'd1;
                end
                RD_HI: begin
                    state     <= LAUNCH;
                    op_q[7:0] <= bus.mem_rdata;
                    rd_q      <= 1'b0;
                    cstart_q  <= 1'b1;
`ifdef CONV_TIMEOUT_EN
                    // terminal count 0 lands on the 255th WAIT cycle
                    tmr       <= 8'd254;
`endif
                end
                LAUNCH: begin
                    state      <= WAIT;
                    op_q[15:8] <= bus.mem_rdata;
                    cstart_q   <= 1'b0;
                end
                WAIT: begin
                    if (wait_exit) begin
                        state   <= WR_LO;
                        res_hi  <= wait_res[15:8];
                        wdata_q <= wait_res[7:0];
                        addr_q  <= DST_BASE + k_off;
                        we_q    <= 1'b1;
`ifdef CONV_TIMEOUT_EN
                        if (!bus.conv_done) err_q <= 1'b1;
                    end else begin
                        tmr <= tmr - 8'd1;
`endif
                    end
                end
                WR_LO: begin
                    state   <= WR_HI;
                    addr_q  <= DST_BASE + k_off + 8'd1;
                    wdata_q <= res_hi;
                end
                WR_HI: begin
                    we_q <= 1'b0;
                    if (k < LAST_K) begin
                        state  <= RD_LO;
                        k      <= k + 7'd1;
                        addr_q <= SRC_BASE + k_nxt_off;
                        rd_q   <= 1'b1;
                    end else begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // High byte is forwarded from mem_rdata during LAUNCH so the operand is whole
    // in the same cycle as conv_start; afterwards it comes from the register.
    assign bus.conv_operand = (state == LAUNCH) ? {bus.mem_rdata, op_q[7:0]} : op_q;
    assign bus.conv_start   = cstart_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_rd       = rd_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_wdata    = wdata_q;
    assign done             = done_q;
    assign busy             = busy_q;

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter NUM_OPS, default 1: operand count per start (1..128).
REQ-002 SHALL have parameter SRC_BASE, default 8'd0: byte address of first source operand.
REQ-003 SHALL have parameter DST_BASE, default 8'd2: byte address of first result.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  testbench request to begin a batch.
REQ-007 SHALL have port done  output  1  batch complete / ready for next start.
REQ-008 SHALL have port busy  output  1  batch in progress.
REQ-009 SHALL have port mem_addr  output  8  data memory byte address.
REQ-010 SHALL have port mem_rd  output  1  read strobe; mem_rdata valid next cycle.
REQ-011 SHALL have port mem_rdata  input  8  memory read data.
REQ-012 SHALL have port mem_we  output  1  write enable.
REQ-013 SHALL have port mem_wdata  output  8  memory write data.
REQ-014 SHALL have port conv_start  output  1  one-cycle launch pulse to converter.
REQ-015 SHALL have port conv_operand  output  16  fix/int operand, stable from launch until result captured.
REQ-016 SHALL have port conv_done  input  1  converter result valid.
REQ-017 SHALL have port conv_result  input  16  float16 result.
REQ-018 SHALL have port err  output  1  sticky timeout flag (see Configuration).

Function
REQ-019 SHALL implement states IDLE, RD_LO, RD_HI, LAUNCH, WAIT, WR_LO, WR_HI, DONE.
REQ-020 SHALL leave IDLE or DONE for RD_LO on start=1; start in any other state ignored.
REQ-021 SHALL, in RD_LO, drive mem_addr=SRC_BASE+2k, mem_rd=1 (k = op index, 7 bits).
REQ-022 SHALL, in RD_HI, capture mem_rdata into operand[7:0] and drive mem_addr=SRC_BASE+2k+1, mem_rd=1.
REQ-023 SHALL, in LAUNCH, capture mem_rdata into operand[15:8] and assert conv_start for exactly one cycle.
REQ-024 SHALL remain in WAIT until conv_done=1, then capture conv_result; conv_done outside WAIT ignored.
REQ-025 SHALL, in WR_LO, drive mem_we=1, mem_addr=DST_BASE+2k, mem_wdata=result[7:0].
REQ-026 SHALL, in WR_HI, drive mem_we=1, mem_addr=DST_BASE+2k+1, mem_wdata=result[15:8].
REQ-027 SHALL go WR_HI->RD_LO with k+1 if k<NUM_OPS-1, else WR_HI->DONE.
REQ-028 SHALL compute addresses modulo 256 (wrap 8'hFF->8'h00).
REQ-029 SHALL give 6 cycles per op when conv_done arrives the cycle after conv_start; 5+W cycles for W WAIT cycles.
REQ-030 SHALL hold done=1 only in DONE and busy=1 in RD_LO..WR_HI; never both.
REQ-031 SHALL never assert mem_rd and mem_we together; both 0 in IDLE, WAIT, DONE.
REQ-032 SHALL clear k to 0 on every accepted start.

Reset
REQ-033 SHALL, on reset=0 at any time, enter IDLE asynchronously: done, busy, mem_rd, mem_we, conv_start, err = 0; mem_addr, mem_wdata, conv_operand, k = 0.
REQ-034 SHALL, on reset mid-batch, abandon pending memory writes; no write after reset assertion.

Configuration
REQ-035 SHALL, with CONV_TIMEOUT_EN defined, count WAIT cycles in 8 bits; on reaching 255 without conv_done, set err=1, use result 16'h7E00, proceed to WR_LO.
REQ-036 SHALL, without CONV_TIMEOUT_EN, wait indefinitely in WAIT and tie err to 0.
REQ-037 SHALL clear err only on reset or an accepted start.

Verification
REQ-038 SHALL test: NUM_OPS=1, dm[0]=8'h00, dm[1]=8'h01, converter returns 16'h3C00 one cycle after launch -> conv_operand=16'h0100, dm[2]=8'h00, dm[3]=8'h3C, done rises 6 cycles after first RD_LO cycle.
REQ-039 SHALL test: NUM_OPS=3, operands 16'h0001/16'h8000/16'hFFFF, converter echoes ~operand -> results 16'hFFFE/16'h7FFF/16'h0000 at DST_BASE+0..5.
REQ-040 SHALL test: converter delays conv_done 10 cycles -> WAIT 10 cycles, conv_operand stable throughout, one conv_start pulse per op.
REQ-041 SHALL test: reset asserted during WAIT of op 1 of 3 -> immediate IDLE, outputs at reset values, no write to DST_BASE+2.
REQ-042 SHALL test: start pulsed while busy -> ignored; start in DONE -> new batch, done low next cycle.
REQ-043 SHALL test: CONV_TIMEOUT_EN defined, conv_done never asserted -> err=1 after 255 WAIT cycles, 8'h00/8'h7E written, done=1.
